multicycle_alu: RTL

Parametrised, clocked successor to the datapath's combinational 8-bit ALU. It accepts operand pairs through a valid/ready handshake and adds SUB, shifts and an iterative shift-add multiply to the FWD/ADD/AND/OR set. It returns a registered result with ZERO and CARRY flags. It sits between register-file read and writeback, and the stall logic can use BUSY.

---
 rtl/multicycle_alu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: clocked ALU with a valid/ready handshake on both sides.
// Single-cycle ops (FWD/ADD/AND/OR/SUB/SLL/SRL) register their result on
// the accept edge. MUL runs an LSB-first shift-add over WIDTH cycles.
// Ports:
//   CLK, RESET_N              clock, async active-low reset
//   IN_VALID/IN_READY         operand handshake (IN_READY comb. from OUT_READY)
//   DATA1, DATA2, SELECT      operands and op code (DATA2 = shift amount)
//   OUT_VALID/OUT_READY       result handshake
//   RESULT, ZERO, CARRY       registered result and flags
//   BUSY                      multiply iterating
module multicycle_alu #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY
);
  localparam int CW = SHW + 1;  // counter must hold the value WIDTH

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic [2*WIDTH-1:0]   acc_nxt;

  assign IN_READY  = (state_q == S_IDLE) | ((state_q == S_DONE) & OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q == S_EXEC);
  assign RESULT    = result_q;
  assign ZERO      = zero_q;
  assign CARRY     = carry_q;

  // Single-cycle datapath; the extra MSB of diff is the unsigned borrow.
  always_comb begin
    sum     = {1'b0, DATA1} + {1'b0, DATA2};
    diff    = {1'b0, DATA1} - {1'b0, DATA2};
    alu_res = DATA2;
    alu_c   = 1'b0;
    case (SELECT)
      3'b000: alu_res = DATA2;
      3'b001: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      3'b010: alu_res = DATA1 & DATA2;
      3'b011: alu_res = DATA1 | DATA2;
      3'b100: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      3'b101: alu_res = DATA1 << DATA2[SHW-1:0];
      3'b110: alu_res = DATA1 >> DATA2[SHW-1:0];
      default: alu_res = DATA2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_EXEC: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration: publish straight from the final partial sum.
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = acc_nxt[WIDTH-1:0];
          zero_d   = (acc_nxt[WIDTH-1:0] == '0);
          carry_d  = |acc_nxt[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE: if (OUT_READY) state_d = S_IDLE;
      default: ;
    endcase

    // Accept overrides the DONE->IDLE drain so ops stream one per cycle.
    if (accept) begin
      if (SELECT == 3'b111) begin
        state_d  = S_EXEC;
        mcand_d  = {{WIDTH{1'b0}}, DATA1};
        mplier_d = DATA2;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
